// File: rtl/arb_pkg.sv
// Types and helpers shared by the burst engine, its data mux and arbiter-side checkers.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2,
        REL  = 2'd3
    } state_t;

    typedef struct packed {
        logic [1:0] idx;
        logic       valid;
        logic       multi;
    } onehot_t;

    // valid: exactly one bit set (idx is its position); multi: two or more bits set
    function automatic onehot_t onehot_idx(input logic [NUM_REQ-1:0] v);
        onehot_t     r;
        int unsigned n;
        r = '0;
        n = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[i]) begin
                r.idx = 2'(i);
                n++;
            end
        end
        r.valid = (n == 32'd1);
        r.multi = (n > 32'd1);
        return r;
    endfunction

endpackage

// File: rtl/arb_owner_mux.sv
// Selects the owning master's write data and decodes the incoming grant vector.
module arb_owner_mux
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [NUM_REQ-1:0] i_gnt,
    input  logic [1:0]         i_owner,
    input  logic [WIDTH-1:0]   i_data0,
    input  logic [WIDTH-1:0]   i_data1,
    input  logic [WIDTH-1:0]   i_data2,
    input  logic [WIDTH-1:0]   i_data3,
    output logic [WIDTH-1:0]   o_data,
    output onehot_t            o_gnt_dec
);

    always_comb begin
        o_data = i_data0;
        case (i_owner)
            2'd0:    o_data = i_data0;
            2'd1:    o_data = i_data1;
            2'd2:    o_data = i_data2;
            default: o_data = i_data3;
        endcase
    end

    assign o_gnt_dec = onehot_idx(i_gnt);

endmodule

// File: rtl/arb_burst_engine.sv
// Moves a fixed-length burst from the granted master to a shared valid/ready slave port.
module arb_burst_engine
    import arb_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BEATS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gnt0,
    input  logic             gnt1,
    input  logic             gnt2,
    input  logic             gnt3,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic [WIDTH-1:0] data2,
    input  logic [WIDTH-1:0] data3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             done0,
    output logic             done1,
    output logic             done2,
    output logic             done3,
    output logic             busy,
    output logic             err,
    output logic             aborted
);

    localparam int unsigned   CW        = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    state_t               r_state;
    logic [1:0]           r_owner;
    logic [CW-1:0]        r_beat_cnt;
    logic [NUM_REQ-1:0]   r_done;
    logic                 r_err;
    logic                 r_aborted;

    logic [NUM_REQ-1:0]   w_gnt;
    logic [NUM_REQ-1:0]   w_owner_mask;
    logic                 w_owner_gnt;
    logic                 w_other_gnt;
    onehot_t              w_gnt_dec;

    assign w_gnt        = {gnt3, gnt2, gnt1, gnt0};
    assign w_owner_mask = NUM_REQ'(1) << r_owner;
    assign w_owner_gnt  = |(w_gnt & w_owner_mask);
    assign w_other_gnt  = |(w_gnt & ~w_owner_mask);

    arb_owner_mux #(
        .WIDTH(WIDTH)
    ) u_owner_mux (
        .i_gnt    (w_gnt),
        .i_owner  (r_owner),
        .i_data0  (data0),
        .i_data1  (data1),
        .i_data2  (data2),
        .i_data3  (data3),
        .o_data   (out_data),
        .o_gnt_dec(w_gnt_dec)
    );

    // Burst FSM; the beat counter leaves XFER on the last beat so it never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_owner    <= 2'd0;
            r_beat_cnt <= '0;
            r_done     <= '0;
            r_err      <= 1'b0;
            r_aborted  <= 1'b0;
        end else begin
            r_done    <= '0;
            r_err     <= 1'b0;
            r_aborted <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_gnt_dec.multi) begin
                        r_err <= 1'b1;
                    end else if (w_gnt_dec.valid) begin
                        r_owner    <= w_gnt_dec.idx;
                        r_beat_cnt <= '0;
                        r_state    <= XFER;
                    end
                end
                XFER: begin
                    if (w_other_gnt) begin
                        r_err <= 1'b1;
                    end
                    // A lost grant wins over a beat accepted in the same cycle
                    if (!w_owner_gnt) begin
                        r_aborted <= 1'b1;
                        r_state   <= IDLE;
                    end else if (out_ready) begin
                        if (r_beat_cnt == LAST_BEAT) begin
                            r_done  <= w_owner_mask;
                            r_state <= DONE;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= REL;
                end
                REL: begin
                    if (!w_owner_gnt) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign out_valid = (r_state == XFER);
    assign busy      = (r_state != IDLE);
    assign done0     = r_done[0];
    assign done1     = r_done[1];
    assign done2     = r_done[2];
    assign done3     = r_done[3];
    assign err       = r_err;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_arb_burst_engine.sv
// Scoreboard bench for arb_burst_engine: directed bursts, backpressure, violations, abort, rotation, reset.
module tb_arb_burst_engine;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BEATS = 4;

    typedef enum logic [1:0] {EV_BEAT, EV_DONE, EV_ERR, EV_ABORT} ev_kind_t;
    typedef struct packed {
        ev_kind_t   kind;
        logic [7:0] val;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       man_gnt;
    logic [3:0]       gnt;
    logic [WIDTH-1:0] data0, data1, data2, data3;
    logic             out_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             done0, done1, done2, done3;
    logic [3:0]       done_v;
    logic             busy, err, aborted;

    logic             use_arb;
    logic [3:0]       arb_gnt;
    logic [3:0]       req;
    logic [1:0]       arb_last;

    ev_t              exp_q[$];
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    assign gnt    = use_arb ? arb_gnt : man_gnt;
    assign done_v = {done3, done2, done1, done0};

    arb_burst_engine #(
        .WIDTH(WIDTH),
        .BEATS(BEATS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .gnt0     (gnt[0]),
        .gnt1     (gnt[1]),
        .gnt2     (gnt[2]),
        .gnt3     (gnt[3]),
        .data0    (data0),
        .data1    (data1),
        .data2    (data2),
        .data3    (data3),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .done0    (done0),
        .done1    (done1),
        .done2    (done2),
        .done3    (done3),
        .busy     (busy),
        .err      (err),
        .aborted  (aborted)
    );

    // Reference round-robin arbiter with registered grants; masters drop req on their done
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] c;
        for (int k = 1; k <= 4; k++) begin
            c = last + 2'(k);
            if (r[c]) return {1'b1, c};
        end
        return 3'b000;
    endfunction

    always @(posedge clk) begin
        logic [2:0] pick;
        if (!use_arb) begin
            arb_gnt  <= 4'b0;
            arb_last <= 2'd3;
            req      <= 4'hf;
        end else begin
            req <= req & ~done_v;
            if ((arb_gnt & req) == 4'b0) begin
                pick = rr_pick(req, arb_last);
                if (pick[2]) begin
                    arb_gnt  <= 4'b1 << pick[1:0];
                    arb_last <= pick[1:0];
                end else begin
                    arb_gnt <= 4'b0;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_ev(input ev_kind_t k, input logic [7:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic expect_burst(input logic [7:0] d, input int idx);
        for (int b = 0; b < int'(BEATS); b++) expect_ev(EV_BEAT, d);
        expect_ev(EV_DONE, 8'(4'b0001 << idx));
    endtask

    task automatic observe(input ev_kind_t k, input logic [7:0] v, input string name);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s unexpected event actual=%0h expected=none at %0t", name, v, $time);
        end else begin
            e = exp_q.pop_front();
            chk({name, "_kind"}, 32'(k), 32'(e.kind));
            chk(name, 32'(v), 32'(e.val));
        end
    endtask

    // Monitor: every DUT-presented event is matched against the expected queue
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) observe(EV_BEAT, out_data, "beat");
        if ((|done_v) === 1'b1) observe(EV_DONE, 8'(done_v), "done");
        if (err === 1'b1) observe(EV_ERR, 8'h00, "err");
        if (aborted === 1'b1) observe(EV_ABORT, 8'h00, "aborted");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for the owner's done, then release its grant and wait for IDLE
    task automatic wait_done_release(input int idx);
        int n;
        n = 0;
        while (done_v[idx] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("done_seen", 32'(done_v[idx]), 32'd1);
        chk("busy_in_done", 32'(busy), 32'd1);
        chk("no_valid_in_done", 32'(out_valid), 32'd0);
        tick();
        chk("busy_in_rel", 32'(busy), 32'd1);
        man_gnt[idx] = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 10) begin
            tick();
            n++;
        end
        chk("release_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int pat[7];
        pat = '{1, 0, 0, 1, 1, 0, 1};
        rst       = 1'b1;
        use_arb   = 1'b0;
        man_gnt   = 4'b0;
        out_ready = 1'b0;
        data0 = 8'h00; data1 = 8'h00; data2 = 8'h00; data3 = 8'h00;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_done", 32'(done_v), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_aborted", 32'(aborted), 32'd0);
        rst = 1'b0;
        tick();

        // Single burst from master 1
        data1     = 8'hA5;
        out_ready = 1'b1;
        man_gnt   = 4'b0010;
        expect_burst(8'hA5, 1);
        chk("grant_cycle_no_valid", 32'(out_valid), 32'd0);
        tick();
        chk("first_valid_latency", 32'(out_valid), 32'd1);
        chk("first_busy", 32'(busy), 32'd1);
        wait_done_release(1);

        // Backpressure on master 2
        data2     = 8'h3C;
        out_ready = 1'b0;
        man_gnt   = 4'b0100;
        expect_burst(8'h3C, 2);
        tick();
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i][0];
            if (pat[i] == 0) begin
                #2;
                chk("bp_hold_valid", 32'(out_valid), 32'd1);
                chk("bp_hold_data", 32'(out_data), 32'h3C);
            end
            tick();
        end
        chk("bp_done_timing", 32'(done_v), 32'b0100);
        out_ready = 1'b1;
        wait_done_release(2);

        // Two grants at once, then master 3 alone
        data3   = 8'h5A;
        man_gnt = 4'b1001;
        expect_ev(EV_ERR, 8'h00);
        tick();
        chk("viol_no_valid", 32'(out_valid), 32'd0);
        chk("viol_not_busy", 32'(busy), 32'd0);
        man_gnt = 4'b1000;
        expect_burst(8'h5A, 3);
        wait_done_release(3);

        // Abort after two accepted beats on master 0
        data0   = 8'h11;
        man_gnt = 4'b0001;
        expect_ev(EV_BEAT, 8'h11);
        expect_ev(EV_BEAT, 8'h11);
        expect_ev(EV_ABORT, 8'h00);
        tick();
        tick();
        tick();
        man_gnt   = 4'b0000;
        out_ready = 1'b0;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_no_done", 32'(done_v), 32'd0);
        out_ready = 1'b1;
        data1     = 8'h77;
        man_gnt   = 4'b0010;
        expect_burst(8'h77, 1);
        wait_done_release(1);

        // Rotation through all four masters with the reference arbiter
        data0 = 8'hC0; data1 = 8'hC1; data2 = 8'hC2; data3 = 8'hC3;
        for (int m = 0; m < 4; m++) expect_burst(8'(8'hC0 + m), m);
        use_arb = 1'b1;
        tick();
        n = 0;
        while (!(req == 4'b0 && busy == 1'b0 && arb_gnt == 4'b0) && n < 200) begin
            tick();
            n++;
        end
        chk("chain_complete", 32'(n < 200), 32'd1);
        use_arb = 1'b0;
        tick();

        // Reset in the middle of a master 2 burst
        data2   = 8'h99;
        man_gnt = 4'b0100;
        expect_ev(EV_BEAT, 8'h99);
        expect_ev(EV_BEAT, 8'h99);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_done", 32'(done_v), 32'd0);
        chk("mrst_aborted", 32'(aborted), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        expect_burst(8'h99, 2);
        tick();
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        wait_done_release(2);

        tick();
        tick();
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
